// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared constants and entry layout for the CDB writeback arbiter.
// Lane indices, default sizing and the {rrf_we, tag, data} entry format.
package cdb_writeback_arbiter_pkg;

    localparam int CORE_DATA_LEN = 32;
    localparam int CORE_RRF_SEL  = 6;

    localparam int CDB_NUM_SRC    = 3;
    localparam int CDB_NUM_PORTS  = 2;
    localparam int CDB_FIFO_DEPTH = 4;
    localparam int CDB_SRC_W      = 2;

    localparam logic [CDB_SRC_W-1:0] CDB_SRC_ALU    = 2'd0;
    localparam logic [CDB_SRC_W-1:0] CDB_SRC_BRANCH = 2'd1;
    localparam logic [CDB_SRC_W-1:0] CDB_SRC_MEM    = 2'd2;

    typedef struct packed {
        logic                     rrf_we;
        logic [CORE_RRF_SEL-1:0]  tag;
        logic [CORE_DATA_LEN-1:0] data;
    } cdb_entry_t;

    function automatic int cdb_entry_w(input int data_len, input int rrf_sel);
        return 1 + rrf_sel + data_len;
    endfunction

endpackage

// File: rtl/cdb_writeback_arbiter_src_fifo.sv
// Per-lane result FIFO: push/pop/flush with head, count and full/empty.
// A full FIFO accepts a push only when it pops in the same cycle.
module cdb_src_fifo #(
    parameter int W     = 39,
    parameter int DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [W-1:0]          data_i,
    output logic [W-1:0]          head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = data_i;
                wr_d        = wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Round-robin scheduler of ALU/Branch/Mem results onto registered CDB ports.
// Optional same-cycle FIFO bypass when CDB_BYPASS_EN is defined.
module cdb_writeback_arbiter
    import cdb_writeback_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = CDB_NUM_SRC,
    parameter int NUM_PORTS  = CDB_NUM_PORTS,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
    parameter int DATA_LEN   = CORE_DATA_LEN,
    parameter int RRF_SEL    = CORE_RRF_SEL
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          flush_i,
    input  logic [NUM_SRC-1:0]            src_valid_i,
    input  logic [NUM_SRC-1:0]            src_rrf_we_i,
    input  logic [NUM_SRC*RRF_SEL-1:0]    src_tag_i,
    input  logic [NUM_SRC*DATA_LEN-1:0]   src_data_i,
    output logic [NUM_SRC-1:0]            src_stall_o,
    output logic [NUM_PORTS-1:0]          cdb_valid_o,
    output logic [NUM_PORTS-1:0]          cdb_rrf_we_o,
    output logic [NUM_PORTS*RRF_SEL-1:0]  cdb_tag_o,
    output logic [NUM_PORTS*DATA_LEN-1:0] cdb_data_o,
    output logic [NUM_PORTS*2-1:0]        cdb_src_o,
    output logic                          overflow_o
);

    localparam int EW = cdb_entry_w(DATA_LEN, RRF_SEL);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = 3;

    logic [EW-1:0]  in_ent [NUM_SRC];
    logic [EW-1:0]  head   [NUM_SRC];
    logic [EW-1:0]  ent    [NUM_SRC];
    logic [CW-1:0]  count  [NUM_SRC];
    logic [RW-1:0]  pos    [NUM_SRC];
    logic [RW-1:0]  rank   [NUM_SRC];
    logic [RW-1:0]  best;
    logic           any_grant;

    logic [NUM_SRC-1:0] full, empty, avail, grant, push, pop;

    logic [1:0]                    rr_ptr_q, rr_ptr_d;
    logic                          ovf_q, ovf_d;
    logic [NUM_PORTS-1:0]          valid_q, valid_d;
    logic [NUM_PORTS-1:0]          we_q, we_d;
    logic [NUM_PORTS*RRF_SEL-1:0]  tag_q, tag_d;
    logic [NUM_PORTS*DATA_LEN-1:0] data_q, data_d;
    logic [NUM_PORTS*2-1:0]        src_q, src_d;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
        assign in_ent[k] = {src_rrf_we_i[k],
                            src_tag_i[k*RRF_SEL +: RRF_SEL],
                            src_data_i[k*DATA_LEN +: DATA_LEN]};

        cdb_src_fifo #(
            .W     (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .flush_i (flush_i),
            .push_i  (push[k]),
            .pop_i   (pop[k]),
            .data_i  (in_ent[k]),
            .head_o  (head[k]),
            .count_o (count[k]),
            .full_o  (full[k]),
            .empty_o (empty[k])
        );

        // One slot held back for the result already in the EX register.
        assign src_stall_o[k] = (count[k] >= CW'(FIFO_DEPTH-1));
    end

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
`ifdef CDB_BYPASS_EN
            avail[k] = ~empty[k] | (src_valid_i[k] & ~flush_i);
            ent[k]   = empty[k] ? in_ent[k] : head[k];
`else
            avail[k] = ~empty[k];
            ent[k]   = head[k];
`endif
        end
    end

    always_comb begin
        grant     = '0;
        valid_d   = '0;
        we_d      = '0;
        tag_d     = '0;
        data_d    = '0;
        src_d     = '0;
        rr_ptr_d  = rr_ptr_q;
        best      = '0;
        any_grant = 1'b0;
        // Scan order position of each lane relative to rr_ptr.
        for (int k = 0; k < NUM_SRC; k++) begin
            if (RW'(k) >= RW'(rr_ptr_q)) begin
                pos[k] = RW'(k) - RW'(rr_ptr_q);
            end else begin
                pos[k] = RW'(k) + RW'(NUM_SRC) - RW'(rr_ptr_q);
            end
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            rank[k] = '0;
            for (int j = 0; j < NUM_SRC; j++) begin
                if (avail[j] && (pos[j] < pos[k])) begin
                    rank[k] = rank[k] + RW'(1);
                end
            end
            grant[k] = avail[k] && (rank[k] < RW'(NUM_PORTS));
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant[k] && (!any_grant || (pos[k] > best))) begin
                any_grant = 1'b1;
                best      = pos[k];
                rr_ptr_d  = (k == NUM_SRC-1) ? 2'd0 : 2'(k + 1);
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (grant[k] && (rank[k] == RW'(p))) begin
                    valid_d[p]                      = 1'b1;
                    we_d[p]                         = ent[k][EW-1];
                    tag_d[p*RRF_SEL +: RRF_SEL]     = ent[k][DATA_LEN +: RRF_SEL];
                    data_d[p*DATA_LEN +: DATA_LEN]  = ent[k][DATA_LEN-1:0];
                    src_d[p*2 +: 2]                 = 2'(k);
                end
            end
        end
        if (flush_i) begin
            grant    = '0;
            valid_d  = '0;
            we_d     = '0;
            tag_d    = '0;
            data_d   = '0;
            src_d    = '0;
            rr_ptr_d = '0;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            pop[k] = grant[k] & ~empty[k];
`ifdef CDB_BYPASS_EN
            push[k] = src_valid_i[k] & ~flush_i & ~(grant[k] & empty[k]);
`else
            push[k] = src_valid_i[k] & ~flush_i;
`endif
        end
        ovf_d = ovf_q | (|(push & full & ~pop));
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= '0;
            we_q     <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            src_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            src_q    <= src_d;
        end
    end

    assign cdb_valid_o  = valid_q;
    assign cdb_rrf_we_o = we_q;
    assign cdb_tag_o    = tag_q;
    assign cdb_data_o   = data_q;
    assign cdb_src_o    = src_q;
    assign overflow_o   = ovf_q;

endmodule
